pad_attr_ctrl: RTL and testbench
================================

PAD_ATTR_CTRL -- requirements
Module: pad_attr_ctrl

Interface
REQ-001 Parameter NumPads, default 4: number of pads with an attribute register.
REQ-002 Parameter AttrDw, default 32: attribute word width.
REQ-003 Parameter SettleCycles, default 3: wait cycles after each attribute write before the response.
REQ-004 Ports clk_i, input, 1: the only clock; rst_ni, input, 1: reset, synchronous and active-low.
REQ-005 pad_type_i, input, 32: signed pad type word produced by the upstream pad-attribute stage.
REQ-006 req_valid_i, input, 1 / req_ready_o, output, 1: write-request handshake.
REQ-007 req_pad_i, input, $clog2(NumPads) (min 1): target pad index; req_attr_i, input, AttrDw: requested attribute.
REQ-008 rsp_valid_o, output, 1 / rsp_ready_i, input, 1: response handshake.
REQ-009 rsp_attr_o, output, AttrDw: legalized value applied; rsp_err_o, output, 1: request rejected.
REQ-010 attr_o, output, NumPads*AttrDw: applied attribute per pad, pad k at bits [k*AttrDw +: AttrDw]; busy_o, output, 1: FSM not IDLE.

Function
REQ-011 FSM states: IDLE, APPLY, SETTLE, RESP.
REQ-012 req_ready_o = 1 only in IDLE; a request is accepted when req_valid_i && req_ready_o.
REQ-013 On acceptance, pad_type_i, req_pad_i and req_attr_i are captured; later pad_type_i changes do not affect that request.
REQ-014 Legalization mask from captured pad type: 0 or negative -> all zeros; 1 -> 0x000000FF; 2 -> 0x0000FFFF; >=3 -> all ones; truncated to AttrDw.
REQ-015 Legalized value = req_attr_i AND mask; non-writable bits keep their current register value (WARL).
REQ-016 Valid index: IDLE->APPLY; in APPLY the register is written, visible on attr_o the next cycle.
REQ-017 APPLY->SETTLE when SettleCycles>0, load counter = SettleCycles, decrement each cycle, SETTLE->RESP when counter reaches 1; APPLY->RESP directly when SettleCycles=0.
REQ-018 Index >= NumPads: IDLE->RESP directly, no register written, rsp_err_o=1, rsp_attr_o=0.
REQ-019 RESP: rsp_valid_o=1 held with stable rsp_attr_o/rsp_err_o until rsp_ready_i; RESP->IDLE on handshake.
REQ-020 Latency, valid index, rsp_ready_i held high: rsp_valid_o rises SettleCycles+2 cycles after the acceptance edge.
REQ-021 Back-to-back: the next request may be accepted the cycle after the response handshake; at most one request in flight.
REQ-022 busy_o = (state != IDLE).

Reset
REQ-023 rst_ni low at a clock edge, in any state: state=IDLE, all attr_o bits 0, rsp_valid_o=0, rsp_attr_o=0, rsp_err_o=0, counter=0.
REQ-024 A request in flight during reset is discarded with no response; req_ready_o=1 on the first cycle after reset release.

Configuration
REQ-025 Macro PAD_ATTR_CTRL_ERRCNT_EN defined: adds output err_cnt_o, 8 bits, saturating at 255, incremented on each rsp_err_o handshake, cleared by reset.
REQ-026 Macro undefined: err_cnt_o port and counter logic are absent; all other behaviour is identical.

Structure
REQ-027 Package pad_attr_pkg holds the FSM state enum, the pad-type constants (0..3) and the mask constants.
REQ-028 Sub-module pad_attr_warl_mask (combinational: pad type, old value, requested value -> legalized value) is instantiated once.

Verification
REQ-029 Reset: rst_ni=0 for 2 cycles -> attr_o=0, rsp_valid_o=0, req_ready_o=1 after release.
REQ-030 pad_type_i=2, pad 1, attr 0xDEADBEEF, old value 0 -> rsp_attr_o=0x0000BEEF, pad 1 word=0x0000BEEF, rsp_valid_o at acceptance+5 cycles.
REQ-031 pad_type_i=1, pad 0 holding 0x12345600, attr 0xFFFFFFAB -> pad 0=0x123456AB; pad_type_i=0 -> pad unchanged.
REQ-032 req_pad_i=5 with NumPads=4 -> rsp_err_o=1, rsp_attr_o=0, rsp_valid_o at acceptance+1, attr_o unchanged; err_cnt_o=1 when macro defined.
REQ-033 rsp_ready_i held low 10 cycles in RESP -> rsp_valid_o and data stable, req_ready_o=0, second req_valid_i not accepted until handshake.
REQ-034 rst_ni asserted in SETTLE -> IDLE next cycle, no response, pad register=0; SettleCycles=0 build -> rsp_valid_o at acceptance+2.

Source files
------------

// File: rtl/pad_attr_pkg.sv
// Shared types for the pad attribute controller: FSM states, pad-type codes
// and the 32-bit legalization masks that go with each pad type.
package pad_attr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic signed [31:0] PAD_TYPE_NONE = 32'sd0;
  localparam logic signed [31:0] PAD_TYPE_BYTE = 32'sd1;
  localparam logic signed [31:0] PAD_TYPE_HALF = 32'sd2;
  localparam logic signed [31:0] PAD_TYPE_FULL = 32'sd3;

  localparam logic [31:0] MASK_NONE = 32'h0000_0000;
  localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;
  localparam logic [31:0] MASK_FULL = 32'hFFFF_FFFF;

  // Zero and negative types own no writable bits; anything above HALF owns all.
  function automatic logic [31:0] type_mask(input logic signed [31:0] pad_type);
    if (pad_type <= PAD_TYPE_NONE)      return MASK_NONE;
    else if (pad_type == PAD_TYPE_BYTE) return MASK_BYTE;
    else if (pad_type == PAD_TYPE_HALF) return MASK_HALF;
    else                                return MASK_FULL;
  endfunction

endpackage

// File: rtl/pad_attr_warl_mask.sv
// Combinational WARL legalization: writable bits come from the request,
// the rest keep the register's current value.
module pad_attr_warl_mask
  import pad_attr_pkg::*;
#(
  parameter int AttrDw = 32
) (
  input  logic signed [31:0]       i_pad_type,
  input  logic        [AttrDw-1:0] i_old,
  input  logic        [AttrDw-1:0] i_req,
  output logic        [AttrDw-1:0] o_legal
);

  logic [31:0]       w_mask32;
  logic [AttrDw-1:0] w_mask;

  assign w_mask32 = type_mask(i_pad_type);

  // The full mask must cover every bit even when AttrDw is wider than 32.
  always_comb begin
    w_mask = '0;
    if (w_mask32 == MASK_FULL) w_mask = '1;
    else                       w_mask = AttrDw'(w_mask32);
  end

  assign o_legal = (i_req & w_mask) | (i_old & ~w_mask);

endmodule

// File: rtl/pad_attr_ctrl.sv
// Per-pad attribute register bank with a write/settle/respond FSM.
// Optional PAD_ATTR_CTRL_ERRCNT_EN adds a saturating rejected-request counter.
module pad_attr_ctrl
  import pad_attr_pkg::*;
#(
  parameter int NumPads      = 4,
  parameter int AttrDw       = 32,
  parameter int SettleCycles = 3,
  localparam int PadW        = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic signed [31:0]        pad_type_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [PadW-1:0]           req_pad_i,
  input  logic [AttrDw-1:0]         req_attr_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [AttrDw-1:0]         rsp_attr_o,
  output logic                      rsp_err_o,
  output logic [NumPads*AttrDw-1:0] attr_o,
  output logic                      busy_o
`ifdef PAD_ATTR_CTRL_ERRCNT_EN
  ,
  output logic [7:0]                err_cnt_o
`endif
);

  localparam int CntW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;

  state_e             r_state;
  logic signed [31:0] r_pad_type;
  logic [PadW-1:0]    r_pad;
  logic [AttrDw-1:0]  r_req_attr;
  logic [AttrDw-1:0]  r_attr [NumPads];
  logic [CntW-1:0]    r_cnt;
  logic               r_rsp_valid;
  logic [AttrDw-1:0]  r_rsp_attr;
  logic               r_rsp_err;

  logic [AttrDw-1:0]  w_old;
  logic [AttrDw-1:0]  w_legal;
  logic               w_idx_ok;

  assign w_idx_ok = (32'(req_pad_i) < 32'(NumPads));

  always_comb begin
    w_old = '0;
    for (int k = 0; k < NumPads; k++) begin
      if (r_pad == PadW'(k)) w_old = r_attr[k];
    end
  end

  pad_attr_warl_mask #(
    .AttrDw(AttrDw)
  ) u_warl (
    .i_pad_type(r_pad_type),
    .i_old     (w_old),
    .i_req     (r_req_attr),
    .o_legal   (w_legal)
  );

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid and its payload hold steady until that edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_pad_type  <= '0;
      r_pad       <= '0;
      r_req_attr  <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_attr  <= '0;
      r_rsp_err   <= 1'b0;
      for (int k = 0; k < NumPads; k++) r_attr[k] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_pad_type <= pad_type_i;
            r_pad      <= req_pad_i;
            r_req_attr <= req_attr_i;
            if (w_idx_ok) begin
              r_state <= ST_APPLY;
            end else begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_attr  <= '0;
            end
          end
        end
        ST_APPLY: begin
          for (int k = 0; k < NumPads; k++) begin
            if (r_pad == PadW'(k)) r_attr[k] <= w_legal;
          end
          r_rsp_attr <= w_legal;
          r_rsp_err  <= 1'b0;
          if (SettleCycles > 0) begin
            r_cnt   <= CntW'(SettleCycles);
            r_state <= ST_SETTLE;
          end else begin
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == CntW'(1)) begin
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PAD_ATTR_CTRL_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if (r_state == ST_RESP && rsp_ready_i && r_rsp_err && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

  for (genvar k = 0; k < NumPads; k++) begin : g_attr
    assign attr_o[k*AttrDw +: AttrDw] = r_attr[k];
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_attr_o  = r_rsp_attr;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_pad_attr_ctrl.sv
// Scoreboard bench for pad_attr_ctrl: directed requests push expected
// {err, attr} responses, a monitor pops them on each response handshake.
module tb_pad_attr_ctrl;

  localparam int NP = 5;
  localparam int DW = 32;
  localparam int PW = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [31:0] pad_type;
  logic               req_valid;
  logic               req_ready;
  logic [PW-1:0]      req_pad;
  logic [DW-1:0]      req_attr;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_attr;
  logic               rsp_err;
  logic [NP*DW-1:0]   attr;
  logic               busy;

  logic signed [31:0] s0_pad_type;
  logic               s0_req_valid;
  logic               s0_req_ready;
  logic [PW-1:0]      s0_req_pad;
  logic [DW-1:0]      s0_req_attr;
  logic               s0_rsp_valid;
  logic [DW-1:0]      s0_rsp_attr;
  logic               s0_rsp_err;
  logic [NP*DW-1:0]   s0_attr;
  logic               s0_busy;

`ifdef PAD_ATTR_CTRL_ERRCNT_EN
  logic [7:0] err_cnt;
  logic [7:0] s0_err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] m_attr [NP];

  always #5 clk = ~clk;

  pad_attr_ctrl #(.NumPads(NP), .AttrDw(DW), .SettleCycles(3)) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pad_type_i (pad_type),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_pad_i  (req_pad),
    .req_attr_i (req_attr),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_attr_o (rsp_attr),
    .rsp_err_o  (rsp_err),
    .attr_o     (attr),
    .busy_o     (busy)
`ifdef PAD_ATTR_CTRL_ERRCNT_EN
    ,
    .err_cnt_o  (err_cnt)
`endif
  );

  pad_attr_ctrl #(.NumPads(NP), .AttrDw(DW), .SettleCycles(0)) u_dut_s0 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pad_type_i (s0_pad_type),
    .req_valid_i(s0_req_valid),
    .req_ready_o(s0_req_ready),
    .req_pad_i  (s0_req_pad),
    .req_attr_i (s0_req_attr),
    .rsp_valid_o(s0_rsp_valid),
    .rsp_ready_i(1'b1),
    .rsp_attr_o (s0_rsp_attr),
    .rsp_err_o  (s0_rsp_err),
    .attr_o     (s0_attr),
    .busy_o     (s0_busy)
`ifdef PAD_ATTR_CTRL_ERRCNT_EN
    ,
    .err_cnt_o  (s0_err_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_attr(input string name);
    for (int k = 0; k < NP; k++) check(name, 64'(attr[k*DW +: DW]), 64'(m_attr[k]));
  endtask

  // Monitor: one pop per response handshake (valid && ready seen mid-cycle).
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(e[DW]));
        check("rsp_attr", 64'(rsp_attr), 64'(e[DW-1:0]));
      end
    end
  end

  // Called just after a rising edge with the DUT idle.
  task automatic do_req(input logic signed [31:0] ty, input logic [PW-1:0] pad,
                        input logic [DW-1:0] a, input logic [DW-1:0] exp_attr,
                        input logic exp_err, input int exp_lat, input int stall);
    int n;
    pad_type  = ty;
    req_pad   = pad;
    req_attr  = a;
    req_valid = 1'b1;
    rsp_ready = (stall == 0);
    check("req_ready_idle", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    pad_type  = (ty > 0) ? 32'sd0 : 32'sd3;
    req_attr  = '1;
    exp_q.push_back({exp_err, exp_attr});
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    check("latency", 64'(n), 64'(exp_lat));
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_pad   = 3'd4;
        req_attr  = 32'h0;
        pad_type  = 32'sd3;
        @(negedge clk);
        check("stall_valid", 64'(rsp_valid), 64'(1));
        check("stall_attr", 64'(rsp_attr), 64'(exp_attr));
        check("stall_ready", 64'(req_ready), 64'(0));
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("busy_after_hs", 64'(busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; pad_type = '0; req_valid = 1'b0; req_pad = '0; req_attr = '0; rsp_ready = 1'b1;
    s0_pad_type = '0; s0_req_valid = 1'b0; s0_req_pad = '0; s0_req_attr = '0;
    for (int k = 0; k < NP; k++) m_attr[k] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_attr("rst_attr");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", 64'(req_ready), 64'(1));
`ifdef PAD_ATTR_CTRL_ERRCNT_EN
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
`endif

    do_req(32'sd2, 3'd1, 32'hDEADBEEF, 32'h0000BEEF, 1'b0, 5, 0);
    m_attr[1] = 32'h0000BEEF;
    check_attr("half_write");

    do_req(32'sd3, 3'd0, 32'h12345600, 32'h12345600, 1'b0, 5, 0);
    do_req(32'sd1, 3'd0, 32'hFFFFFFAB, 32'h123456AB, 1'b0, 5, 0);
    m_attr[0] = 32'h123456AB;
    check_attr("byte_write");
    do_req(32'sd0, 3'd0, 32'hFFFFFFFF, 32'h123456AB, 1'b0, 5, 0);
    do_req(-32'sd1, 3'd0, 32'h00000000, 32'h123456AB, 1'b0, 5, 0);
    check_attr("ro_type");
    do_req(32'sd7, 3'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 5, 0);
    do_req(32'sd2, 3'd4, 32'h00001111, 32'hA5A51111, 1'b0, 5, 0);
    m_attr[4] = 32'hA5A51111;
    check_attr("warl_keep");

    do_req(32'sd3, 3'd5, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);
    do_req(32'sd3, 3'd7, 32'h12345678, 32'h0, 1'b1, 1, 0);
    check_attr("err_no_write");
`ifdef PAD_ATTR_CTRL_ERRCNT_EN
    check("err_cnt", 64'(err_cnt), 64'(2));
`endif

    do_req(32'sd1, 3'd2, 32'h0000003C, 32'h0000003C, 1'b0, 5, 10);
    m_attr[2] = 32'h0000003C;
    check_attr("stall_no_accept");

    // Reset while the write is settling: register already written, then cleared.
    pad_type = 32'sd3; req_pad = 3'd3; req_attr = 32'h00000055; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("settle_written", 64'(attr[3*DW +: DW]), 64'(32'h55));
    @(posedge clk); #1;
    check("settle_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < NP; k++) m_attr[k] = '0;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_ready", 64'(req_ready), 64'(1));
    check_attr("rst_mid_attr");
`ifdef PAD_ATTR_CTRL_ERRCNT_EN
    check("rst_mid_err_cnt", 64'(err_cnt), 64'(0));
`endif
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("no_rsp_after_rst", 64'(n), 64'(0));
    @(posedge clk); #1;

    do_req(32'sd2, 3'd3, 32'hCAFEF00D, 32'h0000F00D, 1'b0, 5, 0);
    m_attr[3] = 32'h0000F00D;
    check_attr("post_rst_write");

    // SettleCycles = 0 instance.
    s0_pad_type = 32'sd2; s0_req_pad = 3'd0; s0_req_attr = 32'h1234ABCD; s0_req_valid = 1'b1;
    @(posedge clk); #1;
    s0_req_valid = 1'b0;
    s0_pad_type  = 32'sd0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (s0_rsp_valid) break;
    end
    check("s0_latency", 64'(n), 64'(2));
    check("s0_rsp_attr", 64'(s0_rsp_attr), 64'(32'h0000ABCD));
    check("s0_rsp_err", 64'(s0_rsp_err), 64'(0));
    @(posedge clk); #1;
    check("s0_attr0", 64'(s0_attr[DW-1:0]), 64'(32'h0000ABCD));
    check("s0_idle", 64'(s0_busy), 64'(0));

    repeat (2) @(posedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
